// File: rtl/sysctrl_host_pkg.sv
// rtl/sysctrl_host_pkg.sv - shared system-control protocol constants and helpers
package sysctrl_host_pkg;

  // Command codes understood by the system-control responder
  localparam logic [7:0] CMD_STATUS  = 8'd0;
  localparam logic [7:0] CMD_LEDS    = 8'd1;
  localparam logic [7:0] CMD_COLOR   = 8'd2;
  localparam logic [7:0] CMD_BUTTONS = 8'd3;
  localparam logic [7:0] CMD_CONFIG  = 8'd4;
  localparam logic [7:0] CMD_INT     = 8'd5;

  // Status reply: two signature bytes followed by the core id
  localparam logic [7:0] STATUS_SIG0 = 8'h5C;
  localparam logic [7:0] STATUS_SIG1 = 8'h42;
  localparam logic [7:0] CORE_ID     = 8'h02;

  // Config id character selecting the system volume field
  localparam logic [7:0] CONFIG_ID_VOLUME = 8'h41;

  // Largest payload a single request can carry
  localparam int MAXLEN = 4;

  // Requests longer than MAXLEN are truncated rather than rejected
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'(MAXLEN)) ? 3'(MAXLEN) : len;
  endfunction

endpackage

// File: rtl/sysctrl_host.sv
// rtl/sysctrl_host.sv - request-to-strobe host for the system-control byte protocol
module sysctrl_host
  import sysctrl_host_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_cmd,
  input  logic [2:0]            req_len,
  input  logic [31:0]           req_data,
  output logic                  rsp_valid,
  output logic [8*MAXLEN-1:0]   rsp_data,
  output logic                  busy,
  output logic                  data_in_strobe,
  output logic                  data_in_start,
  output logic [7:0]            data_in,
  input  logic [7:0]            data_out
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_BYTE   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // The gap counter counts down to zero, so it is loaded with GAP-1
  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  logic [2:0]  state;
  logic [3:0]  gap_cnt;
  logic [2:0]  idx;
  logic [2:0]  len_q;
  logic [31:0] data_q;
  logic        cap_arm;
  logic [1:0]  cap_idx;
  logic        accept;

  // req_ready is only ever high in IDLE/FINISH, so this is the acceptance edge
  assign accept = req_valid && req_ready;

  // Frame sequencer: every bus output is registered alongside the state change
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      gap_cnt        <= 4'd0;
      idx            <= 3'd0;
      len_q          <= 3'd0;
      data_q         <= 32'd0;
      req_ready      <= 1'b0;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      data_in_strobe <= 1'b0;
      data_in_start  <= 1'b0;
      data_in        <= 8'd0;
    end else begin
      data_in_strobe <= 1'b0;
      data_in_start  <= 1'b0;
      rsp_valid      <= 1'b0;
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (accept) begin
            len_q          <= clamp_len(req_len);
            data_q         <= req_data;
            idx            <= 3'd0;
            busy           <= 1'b1;
            req_ready      <= 1'b0;
            data_in_strobe <= 1'b1;
            data_in_start  <= 1'b1;
            data_in        <= req_cmd;
            state          <= ST_START;
          end else begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_START: begin
          gap_cnt <= GAP_LOAD;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else if (idx < len_q) begin
            data_in_strobe <= 1'b1;
            data_in        <= data_q[{idx[1:0], 3'b000} +: 8];
            state          <= ST_BYTE;
          end else begin
            rsp_valid <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_FINISH;
          end
        end
        ST_BYTE: begin
          idx     <= idx + 3'd1;
          gap_cnt <= GAP_LOAD;
          state   <= ST_WAIT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Reply capture: the responder answers one cycle after a payload strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_data <= '0;
      cap_arm  <= 1'b0;
      cap_idx  <= 2'd0;
    end else begin
      cap_arm <= (state == ST_BYTE);
      cap_idx <= idx[1:0];
      if (accept) begin
        rsp_data <= '0;
      end else if (cap_arm) begin
        rsp_data[{cap_idx, 3'b000} +: 8] <= data_out;
      end
    end
  end

endmodule
